// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO serialising ALU/load results onto the regfile write port.
// Define WB_BYPASS_EN to build the youngest-match forwarding comparators.
module regfile_writeback_queue #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 18,
   parameter int DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_data,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [ADDR_W-1:0]        mem_rd,
   input  logic [DATA_W-1:0]        mem_data,
   output logic                     mem_ready,
   output logic [ADDR_W-1:0]        wb_rd,
   output logic [DATA_W-1:0]        wb_data,
   output logic                     wb_we,
   input  logic [ADDR_W-1:0]        rs1,
   input  logic [ADDR_W-1:0]        rs2,
   output logic                     fwd1_hit,
   output logic                     fwd2_hit,
   output logic [DATA_W-1:0]        fwd1_data,
   output logic [DATA_W-1:0]        fwd2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]     FULL  = CW'(DEPTH);
   localparam logic [CW-1:0]     ROOM2 = CW'(DEPTH - 2);
   localparam logic [ADDR_W:0]   NREG  = (ADDR_W + 1)'(NUM_REGS);

   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [PW-1:0]     mem_slot;
   logic [ADDR_W-1:0] rd_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic       alu_fire, mem_fire;
   logic       alu_keep, mem_keep;
   logic       alu_bad, mem_bad;
   logic       pop;
   logic [1:0] n_push;

   // Readiness looks only at registered count; the same-cycle pop is not credited.
   assign alu_ready = count < FULL;
   assign mem_ready = alu_valid ? (count <= ROOM2) : (count < FULL);

   assign alu_fire = alu_valid & alu_ready;
   assign mem_fire = mem_valid & mem_ready;
   assign alu_bad  = alu_fire & ({1'b0, alu_rd} >= NREG);
   assign mem_bad  = mem_fire & ({1'b0, mem_rd} >= NREG);
   assign alu_keep = alu_fire & (alu_rd != '0) & ~alu_bad;
   assign mem_keep = mem_fire & (mem_rd != '0) & ~mem_bad;

   assign pop      = count != '0;
   assign n_push   = {1'b0, alu_keep} + {1'b0, mem_keep};
   assign mem_slot = tail + PW'(alu_keep);

   always_ff @(posedge clk) begin
      if (alu_keep) begin
         rd_q[tail]   <= alu_rd;
         data_q[tail] <= alu_data;
      end
      if (mem_keep) begin
         rd_q[mem_slot]   <= mem_rd;
         data_q[mem_slot] <= mem_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         wb_we    <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         drop_err <= 1'b0;
      end else begin
         head  <= head + PW'(pop);
         tail  <= tail + PW'(n_push);
         count <= count + CW'(n_push) - CW'(pop);
         wb_we <= pop;
         if (pop) begin
            wb_rd   <= rd_q[head];
            wb_data <= data_q[head];
         end
         if (alu_bad | mem_bad)
            drop_err <= 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   // Scan oldest to youngest so the last match (tail-most) wins.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd2_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_data = '0;
      if (wb_we && wb_rd == rs1) begin
         fwd1_hit  = 1'b1;
         fwd1_data = wb_data;
      end
      if (wb_we && wb_rd == rs2) begin
         fwd2_hit  = 1'b1;
         fwd2_data = wb_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
         logic [PW-1:0] idx;
         idx = head + PW'(k);
         if (CW'(k) < count) begin
            if (rd_q[idx] == rs1) begin
               fwd1_hit  = 1'b1;
               fwd1_data = data_q[idx];
            end
            if (rd_q[idx] == rs2) begin
               fwd2_hit  = 1'b1;
               fwd2_data = data_q[idx];
            end
         end
      end
      if (rs1 == '0) begin
         fwd1_hit  = 1'b0;
         fwd1_data = '0;
      end
      if (rs2 == '0) begin
         fwd2_hit  = 1'b0;
         fwd2_data = '0;
      end
   end
`else
   logic unused_rs;
   assign unused_rs = ^{rs1, rs2};
   assign fwd1_hit  = 1'b0;
   assign fwd2_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed cases plus
// randomized traffic against a queue-based reference model.
module tb_regfile_writeback_queue;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 18;
   localparam int DEPTH    = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              alu_valid, mem_valid;
   logic [4:0]        alu_rd, mem_rd, rs1, rs2;
   logic [63:0]       alu_data, mem_data;
   logic              alu_ready, mem_ready;
   logic [4:0]        wb_rd;
   logic [63:0]       wb_data;
   logic              wb_we;
   logic              fwd1_hit, fwd2_hit;
   logic [63:0]       fwd1_data, fwd2_data;
   logic [2:0]        count;
   logic              drop_err;

   regfile_writeback_queue #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .NUM_REGS(NUM_REGS), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd),
      .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd),
      .mem_data(mem_data), .mem_ready(mem_ready),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
      .rs1(rs1), .rs2(rs2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .count(count), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   ent_t        q[$];
   logic        m_we;
   logic [4:0]  m_rd;
   logic [63:0] m_data;
   logic        m_drop;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] ref_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return '0;
`ifdef WB_BYPASS_EN
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].rd == rs) return {1'b1, q[i].data};
      if (m_we && m_rd == rs) return {1'b1, m_data};
`endif
      return '0;
   endfunction

   function automatic void accept(input logic [4:0] rd, input logic [63:0] d);
      if (rd == 5'd0) return;
      if (int'(rd) >= NUM_REGS) m_drop = 1'b1;
      else q.push_back('{rd: rd, data: d});
   endfunction

   function automatic void model_clear();
      q.delete();
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
      m_drop = 1'b0;
   endfunction

   // Entered and left 1 time unit after a rising edge.
   task automatic step(input logic av, input logic [4:0] ard,
                       input logic [63:0] ad, input logic mv,
                       input logic [4:0] mrd, input logic [63:0] md,
                       input logic [4:0] r1, input logic [4:0] r2,
                       output logic acc_a, output logic acc_m);
      int          pre;
      logic        ar, mr;
      logic [64:0] f;
      ent_t        e;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      rs1 = r1; rs2 = r2;
      #1;
      pre = q.size();
      ar = pre < DEPTH;
      mr = av ? (pre <= DEPTH - 2) : (pre < DEPTH);
      chk("alu_ready", alu_ready, ar);
      chk("mem_ready", mem_ready, mr);
      f = ref_fwd(r1);
      chk("fwd1_hit", fwd1_hit, f[64]);
      chk("fwd1_data", fwd1_data, f[63:0]);
      f = ref_fwd(r2);
      chk("fwd2_hit", fwd2_hit, f[64]);
      chk("fwd2_data", fwd2_data, f[63:0]);
      @(posedge clk);
      if (pre > 0) begin
         e = q.pop_front();
         m_we = 1'b1; m_rd = e.rd; m_data = e.data;
      end else begin
         m_we = 1'b0;
      end
      acc_a = av && ar;
      acc_m = mv && mr;
      if (acc_a) accept(ard, ad);
      if (acc_m) accept(mrd, md);
      #1;
      chk("wb_we", wb_we, m_we);
      chk("wb_rd", wb_rd, m_rd);
      chk("wb_data", wb_data, m_data);
      chk("count", count, q.size());
      chk("drop_err", drop_err, m_drop);
   endtask

   task automatic idle(input int n);
      logic a, m;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a, m);
   endtask

   initial begin
      logic        a, m;
      logic [4:0]  nrd;
      logic [4:0]  ra, rm;
      logic [63:0] da, dm;
      int          sent;

      reset = 1'b1;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      rs1 = 0; rs2 = 0;
      model_clear();
      #1;
      chk("rst_count", count, 0);
      chk("rst_wb_we", wb_we, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_drop", drop_err, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // Single ALU result into an empty FIFO.
      step(1, 5, 64'hAA, 0, 0, 0, 0, 0, a, m);
      chk("single_cnt", count, 1);
      chk("single_we0", wb_we, 0);
      step(0, 0, 0, 0, 0, 0, 5, 0, a, m);
      chk("single_we1", wb_we, 1);
      chk("single_rd", wb_rd, 5);
      chk("single_data", wb_data, 64'hAA);
      step(0, 0, 0, 0, 0, 0, 5, 0, a, m);
      chk("single_we2", wb_we, 0);
      chk("single_cnt0", count, 0);

      // Same-cycle ALU+MEM to the same rd; MEM is younger.
      step(1, 3, 64'h11, 1, 3, 64'h22, 0, 0, a, m);
      chk("pair_cnt", count, 2);
      step(0, 0, 0, 0, 0, 0, 3, 3, a, m);
      chk("pair_wb1", wb_data, 64'h11);
      step(0, 0, 0, 0, 0, 0, 3, 0, a, m);
      chk("pair_wb2", wb_data, 64'h22);
      idle(2);

      // Saturate both producers, holding unaccepted results.
      nrd = 5'd1; sent = 0;
      ra = nrd; da = 64'h100; nrd++;
      rm = nrd; dm = 64'h200; nrd++;
      for (int i = 0; i < 12 && sent < 12; i++) begin
         step(1, ra, da, 1, rm, dm, ra, rm, a, m);
         if (a) begin ra = nrd; da = da + 1; nrd++; sent++; end
         if (m) begin rm = nrd; dm = dm + 1; nrd++; sent++; end
         if (nrd >= 5'd17) nrd = 5'd1;
      end
      idle(6);
      chk("sat_drain", count, 0);

      // Writes to x0 and to an unimplemented register.
      step(1, 0, 64'h5, 1, 20, 64'h6, 0, 0, a, m);
      chk("drop_cnt", count, 0);
      chk("drop_flag", drop_err, 1);
      idle(3);
      chk("drop_sticky", drop_err, 1);

      // Pending rd 7 probed on port 2.
      step(1, 7, 64'h77, 1, 9, 64'h99, 0, 7, a, m);
      step(0, 0, 0, 0, 0, 0, 9, 7, a, m);
      idle(2);

      // Reset mid-drain with count = 3.
      step(1, 1, 64'hA1, 1, 2, 64'hA2, 0, 0, a, m);
      step(1, 3, 64'hA3, 1, 4, 64'hA4, 0, 0, a, m);
      chk("mid_cnt3", count, 3);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_we", wb_we, 0);
      chk("mid_rst_cnt", count, 0);
      chk("mid_rst_drop", drop_err, 0);
      model_clear();
      @(posedge clk); #1;
      chk("mid_hold_we", wb_we, 0);
      reset = 1'b0;
      idle(4);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         ra = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                          : 5'($urandom_range(1, 8));
         rm = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                          : 5'($urandom_range(1, 8));
         da = {$urandom, $urandom};
         dm = {$urandom, $urandom};
         step(1'($urandom_range(0, 1)), ra, da,
              1'($urandom_range(0, 1)), rm, dm,
              5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)), a, m);
      end
      idle(6);
      chk("final_cnt", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
